picture_grid_flip: RTL and testbench
====================================

# picture_grid_flip

Parametrised tile-flip controller for the card-matching screen. It divides a rectangular region of the display into a COLS×ROWS grid of tiles and flips tiles face-up on mouse clicks. It compares each pair of face-up tiles by key and either locks them as matched or turns them back face-down. It also muxes the front-image and background RGB streams per pixel, and sits in the draw_image pipeline after the image ROM readers and before the mouse overlay.

## Interface
- COLS, 4: tile columns
- ROWS, 2: tile rows; N = COLS*ROWS tiles, index t = row*COLS + col
- X0, 64: grid left edge (pixels)
- Y0, 64: grid top edge (pixels)
- TILE_W, 128: tile width (pixels)
- TILE_H, 128: tile height (pixels)
- GAP, 16: gap between adjacent tiles, both axes (pixels)
- KEY_W, 3: width of the pairing key per tile
- HOLD_CYCLES, 65_000_000: mismatch display time in clk cycles (used only with auto-hide)

- clk  in  1  pixel/system clock
- rst  in  1  asynchronous, active-high reset
- mouse_left  in  1  left button level, synchronous to clk
- xpos  in  12  mouse cursor x
- ypos  in  12  mouse cursor y
- hcount  in  11  current pixel x
- vcount  in  11  current pixel y
- rgb_front  in  12  face-up image pixel for (hcount, vcount)
- rgb_back  in  12  background/back-side pixel for (hcount, vcount)
- tile_key  in  N*KEY_W  key of tile t at bits [t*KEY_W +: KEY_W]; two tiles match when their keys are equal
- rgb_out  out  12  muxed pixel, registered
- face_up  out  N  tile currently shown face-up but not yet matched
- matched  out  N  tile locked face-up permanently
- busy  out  1  high while in CMP or HOLD (clicks ignored)

## Operation
- Hit test is combinational, half-open. The cursor is in tile (c, r) when X0 + c*(TILE_W+GAP) <= xpos < that + TILE_W, and likewise in y with Y0, TILE_H. A point in a gap or outside the grid hits nothing.
- A click is a rising edge of mouse_left: the registered previous level is 0 and the current level is 1. Holding the button produces exactly one click.
- A click is valid when it hits tile t, face_up[t]=0, matched[t]=0 and the FSM is in IDLE or ONE.
- FSM states:
  - IDLE: a valid click on t sets face_up[t], stores first=t and goes to ONE.
  - ONE: a valid click on t (necessarily t != first) sets face_up[t], stores second=t and goes to CMP. Any other click is ignored.
  - CMP: one cycle. If the keys are equal, set matched[first] and matched[second], clear their face_up bits and go to IDLE. Otherwise go to HOLD with the counter cleared.
  - HOLD: behaviour depends on the Configuration section. On exit, clear face_up[first] and face_up[second] and go to IDLE.
- Clicks in CMP and HOLD are ignored, except as defined for HOLD without auto-hide.
- Pixel mux: if (hcount, vcount) lies in tile t (same half-open test) and face_up[t] | matched[t], output rgb_front. Otherwise output rgb_back, including in gaps and outside the grid.
- Once all N bits of matched are set, the grid stays static until reset.

## Timing
- Reset values: rgb_out=0, face_up=0, matched=0, busy=0, FSM=IDLE, counter=0, previous mouse_left=0.
- Asynchronous assertion of rst clears everything immediately, including mid-HOLD or mid-CMP.
- A click is detected in the cycle mouse_left is first sampled 1. face_up updates at the next clk edge, one cycle of latency.
- CMP → matched/face_up update at the following edge, two cycles after the second click edge.
- rgb_out has one-cycle latency from hcount/vcount/rgb_front/rgb_back. Upstream must align rgb_front and rgb_back with hcount/vcount.
- The counter width is $clog2(HOLD_CYCLES+1). It does not wrap: it saturates at the exit condition.

## Configuration
- PICTURE_GRID_AUTO_HIDE_EN defined: HOLD counts clk cycles and exits after exactly HOLD_CYCLES cycles in HOLD. Clicks are ignored throughout HOLD.
- Not defined: HOLD has no timer and HOLD_CYCLES is unused. The next click anywhere (hit or not) exits HOLD. That click only turns the pair face-down and never flips another tile.

## Test plan
- Reset, then click tile 0 (xpos=X0, ypos=Y0) → face_up=8'h01 one cycle after the edge; a pixel at (X0,Y0) gives rgb_out=rgb_front one cycle later.
- Keys {0,0,1,1,2,2,3,3}; click tile 0, then tile 1 → matched=8'h03, face_up=0; further clicks on tiles 0/1 are ignored.
- Click tile 0, then tile 2 with AUTO_HIDE_EN and HOLD_CYCLES=10 → busy high; face_up=8'h05 for exactly 10 HOLD cycles, then 0. A click during HOLD has no effect.
- Same mismatch without the macro → face_up stays 8'h05 indefinitely; a click at (0,0) clears it and the next valid click flips normally.
- Click at xpos=X0+TILE_W (gap), a held button over tile 3, and a double click on the same tile → no flip, one flip, and one flip respectively.
- Assert rst during HOLD → all outputs 0 immediately and the FSM returns to IDLE.

Source files
------------

// File: rtl/picture_grid_flip.sv
// Tile-flip controller for the card-matching screen: hit-tests clicks over a COLS x ROWS grid,
// pairs face-up tiles by key and muxes front/back RGB. Optional macro: PICTURE_GRID_AUTO_HIDE_EN.
module picture_grid_flip #(
    parameter int unsigned COLS        = 4,
    parameter int unsigned ROWS        = 2,
    parameter int unsigned X0          = 64,
    parameter int unsigned Y0          = 64,
    parameter int unsigned TILE_W      = 128,
    parameter int unsigned TILE_H      = 128,
    parameter int unsigned GAP         = 16,
    parameter int unsigned KEY_W       = 3,
    parameter int unsigned HOLD_CYCLES = 65_000_000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_mouse_left,
    input  logic [11:0]                   i_xpos,
    input  logic [11:0]                   i_ypos,
    input  logic [10:0]                   i_hcount,
    input  logic [10:0]                   i_vcount,
    input  logic [11:0]                   i_rgb_front,
    input  logic [11:0]                   i_rgb_back,
    input  logic [COLS*ROWS*KEY_W-1:0]    i_tile_key,
    output logic [11:0]                   o_rgb_out,
    output logic [COLS*ROWS-1:0]          o_face_up,
    output logic [COLS*ROWS-1:0]          o_matched,
    output logic                          o_busy
);

    localparam int unsigned N     = COLS * ROWS;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StOne, StCmp, StHold} state_e;

    state_e             r_state;
    logic [N-1:0]       r_face_up;
    logic [N-1:0]       r_matched;
    logic [IDX_W-1:0]   r_first;
    logic [IDX_W-1:0]   r_second;
    logic               r_mouse_prev;
    logic               r_busy;
    logic [11:0]        r_rgb;

`ifdef PICTURE_GRID_AUTO_HIDE_EN
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    logic [CNT_W-1:0]   r_cnt;
`endif

    logic [31:0]        w_x32, w_y32, w_h32, w_v32;
    logic [N-1:0]       w_cur_hit;
    logic [N-1:0]       w_pix_hit;
    logic [N-1:0]       w_hit_free;
    logic               w_click;
    logic               w_valid;
    logic               w_pix_show;
    logic               w_key_eq;
    logic [IDX_W-1:0]   w_click_idx;

    assign w_x32 = {20'd0, i_xpos};
    assign w_y32 = {20'd0, i_ypos};
    assign w_h32 = {21'd0, i_hcount};
    assign w_v32 = {21'd0, i_vcount};

    // Half-open tile rectangles; gaps and the outside of the grid hit nothing.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            localparam int unsigned T  = gr * COLS + gc;
            localparam int unsigned XL = X0 + gc * (TILE_W + GAP);
            localparam int unsigned YT = Y0 + gr * (TILE_H + GAP);
            assign w_cur_hit[T] = (w_x32 >= XL) && (w_x32 < XL + TILE_W) &&
                                  (w_y32 >= YT) && (w_y32 < YT + TILE_H);
            assign w_pix_hit[T] = (w_h32 >= XL) && (w_h32 < XL + TILE_W) &&
                                  (w_v32 >= YT) && (w_v32 < YT + TILE_H);
        end
    end

    assign w_click    = i_mouse_left & ~r_mouse_prev;
    assign w_hit_free = w_cur_hit & ~r_face_up & ~r_matched;
    assign w_valid    = w_click && (|w_hit_free) && (r_state == StIdle || r_state == StOne);
    assign w_pix_show = |(w_pix_hit & (r_face_up | r_matched));
    assign w_key_eq   = i_tile_key[r_first * KEY_W +: KEY_W] ==
                        i_tile_key[r_second * KEY_W +: KEY_W];

    always_comb begin
        w_click_idx = '0;
        for (int unsigned t = 0; t < N; t++) begin
            if (w_hit_free[t]) w_click_idx = IDX_W'(t);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_face_up    <= '0;
            r_matched    <= '0;
            r_first      <= '0;
            r_second     <= '0;
            r_mouse_prev <= 1'b0;
            r_busy       <= 1'b0;
            r_rgb        <= '0;
`ifdef PICTURE_GRID_AUTO_HIDE_EN
            r_cnt        <= '0;
`endif
        end else begin
            r_mouse_prev <= i_mouse_left;
            r_rgb        <= w_pix_show ? i_rgb_front : i_rgb_back;
            unique case (r_state)
                StIdle: begin
                    if (w_valid) begin
                        r_face_up[w_click_idx] <= 1'b1;
                        r_first                <= w_click_idx;
                        r_state                <= StOne;
                    end
                end
                StOne: begin
                    if (w_valid) begin
                        r_face_up[w_click_idx] <= 1'b1;
                        r_second               <= w_click_idx;
                        r_busy                 <= 1'b1;
                        r_state                <= StCmp;
                    end
                end
                StCmp: begin
                    if (w_key_eq) begin
                        r_matched[r_first]  <= 1'b1;
                        r_matched[r_second] <= 1'b1;
                        r_face_up[r_first]  <= 1'b0;
                        r_face_up[r_second] <= 1'b0;
                        r_busy              <= 1'b0;
                        r_state             <= StIdle;
                    end else begin
`ifdef PICTURE_GRID_AUTO_HIDE_EN
                        r_cnt <= '0;
`endif
                        r_state <= StHold;
                    end
                end
                StHold: begin
`ifdef PICTURE_GRID_AUTO_HIDE_EN
                    // Exit on the HOLD_CYCLES-th cycle spent in HOLD; counter never wraps.
                    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        r_face_up[r_first]  <= 1'b0;
                        r_face_up[r_second] <= 1'b0;
                        r_busy              <= 1'b0;
                        r_state             <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`else
                    // Any click exits, and that click never flips a tile.
                    if (w_click) begin
                        r_face_up[r_first]  <= 1'b0;
                        r_face_up[r_second] <= 1'b0;
                        r_busy              <= 1'b0;
                        r_state             <= StIdle;
                    end
`endif
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_rgb_out = r_rgb;
    assign o_face_up = r_face_up;
    assign o_matched = r_matched;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_picture_grid_flip.sv
// Directed self-checking bench for picture_grid_flip (default geometry, HOLD_CYCLES=10).
module tb_picture_grid_flip;

    logic        clk = 1'b0;
    logic        rst;
    logic        mouse_left;
    logic [11:0] xpos, ypos;
    logic [10:0] hcount, vcount;
    logic [11:0] rgb_front, rgb_back;
    logic [23:0] tile_key;
    logic [11:0] rgb_out;
    logic [7:0]  face_up, matched;
    logic        busy;

    int checks = 0;
    int passes = 0;

    picture_grid_flip #(
        .HOLD_CYCLES(10)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mouse_left(mouse_left),
        .i_xpos      (xpos),
        .i_ypos      (ypos),
        .i_hcount    (hcount),
        .i_vcount    (vcount),
        .i_rgb_front (rgb_front),
        .i_rgb_back  (rgb_back),
        .i_tile_key  (tile_key),
        .o_rgb_out   (rgb_out),
        .o_face_up   (face_up),
        .o_matched   (matched),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int tx(input int t);
        return 64 + 144 * (t % 4) + 10;
    endfunction

    function automatic int ty(input int t);
        return 64 + 144 * (t / 4) + 10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mouse_left = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
    endtask

    task automatic click(input int x, input int y);
        xpos = x[11:0];
        ypos = y[11:0];
        mouse_left = 1'b1;
        tick();
        mouse_left = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (rgb_out !== 12'h000) $display("FAIL reset_rgb: got %h want 000", rgb_out);
        else passes++;
        checks++; if (face_up !== 8'h00) $display("FAIL reset_face: got %h want 00", face_up);
        else passes++;
        checks++; if (matched !== 8'h00) $display("FAIL reset_matched: got %h want 00", matched);
        else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_flip_match();
        do_reset();
        hcount = 11'd64; vcount = 11'd64;
        tick();
        checks++; if (rgb_out !== 12'h123) $display("FAIL pix_back: got %h want 123", rgb_out);
        else passes++;
        xpos = 12'd64; ypos = 12'd64;
        mouse_left = 1'b1;
        tick();
        checks++; if (face_up !== 8'h01) $display("FAIL flip_t0: got %h want 01", face_up);
        else passes++;
        mouse_left = 1'b0;
        tick();
        checks++; if (rgb_out !== 12'hABC) $display("FAIL pix_front: got %h want ABC", rgb_out);
        else passes++;
        hcount = 11'd192;
        tick();
        checks++; if (rgb_out !== 12'h123) $display("FAIL pix_gap: got %h want 123", rgb_out);
        else passes++;
        click(tx(1), ty(1));
        checks++; if (matched !== 8'h03) $display("FAIL match01: got %h want 03", matched);
        else passes++;
        checks++; if (face_up !== 8'h00) $display("FAIL match01_face: got %h want 00", face_up);
        else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL match01_busy: got %b want 0", busy);
        else passes++;
        click(tx(0), ty(0));
        click(tx(1), ty(1));
        checks++; if (face_up !== 8'h00 || matched !== 8'h03)
            $display("FAIL matched_ignored: got %h/%h want 00/03", face_up, matched);
        else passes++;
        hcount = 11'd218; vcount = 11'd70;
        tick();
        checks++; if (rgb_out !== 12'hABC) $display("FAIL pix_matched: got %h want ABC", rgb_out);
        else passes++;
    endtask

    task automatic test_mismatch();
        int n;
        do_reset();
        click(tx(0), ty(0));
        xpos = tx(2); ypos = ty(2);
        mouse_left = 1'b1;
        tick();
        mouse_left = 1'b0;
        checks++; if (face_up !== 8'h05 || busy !== 1'b1)
            $display("FAIL mis_enter: got %h/%b want 05/1", face_up, busy);
        else passes++;
`ifdef PICTURE_GRID_AUTO_HIDE_EN
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 3) begin xpos = tx(4); ypos = ty(4); mouse_left = 1'b1; end
            if (i == 5) mouse_left = 1'b0;
            tick();
            if (!busy) break;
            n++;
            checks++; if (face_up !== 8'h05) $display("FAIL hold_face: got %h want 05", face_up);
            else passes++;
        end
        checks++; if (n !== 10) $display("FAIL hold_len: got %0d want 10", n);
        else passes++;
        checks++; if (face_up !== 8'h00 || matched !== 8'h00)
            $display("FAIL hold_exit: got %h/%h want 00/00", face_up, matched);
        else passes++;
`else
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (face_up !== 8'h05 || busy !== 1'b1) n++;
        end
        checks++; if (n !== 0) $display("FAIL hold_stay: got %0d bad cycles want 0", n);
        else passes++;
        xpos = 12'd0; ypos = 12'd0;
        mouse_left = 1'b1;
        tick();
        checks++; if (face_up !== 8'h00 || busy !== 1'b0)
            $display("FAIL hold_exit: got %h/%b want 00/0", face_up, busy);
        else passes++;
        mouse_left = 1'b0;
        tick();
        click(tx(4), ty(4));
        checks++; if (face_up !== 8'h10) $display("FAIL after_hold: got %h want 10", face_up);
        else passes++;
        do_reset();
        click(tx(0), ty(0));
        click(tx(2), ty(2));
        click(tx(4), ty(4));
        checks++; if (face_up !== 8'h00) $display("FAIL exit_noflip: got %h want 00", face_up);
        else passes++;
        click(tx(4), ty(4));
        checks++; if (face_up !== 8'h10) $display("FAIL exit_next: got %h want 10", face_up);
        else passes++;
`endif
    endtask

    task automatic test_hit_edges();
        do_reset();
        click(64 + 128, 74);
        checks++; if (face_up !== 8'h00) $display("FAIL gap_click: got %h want 00", face_up);
        else passes++;
        click(63, 74);
        checks++; if (face_up !== 8'h00) $display("FAIL left_edge: got %h want 00", face_up);
        else passes++;
        click(64 + 127, 64 + 127);
        checks++; if (face_up !== 8'h01) $display("FAIL last_pixel: got %h want 01", face_up);
        else passes++;
        do_reset();
        xpos = tx(3); ypos = ty(3);
        mouse_left = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        mouse_left = 1'b0;
        tick();
        checks++; if (face_up !== 8'h08) $display("FAIL held: got %h want 08", face_up);
        else passes++;
        click(tx(3), ty(3));
        click(tx(3), ty(3));
        checks++; if (face_up !== 8'h08 || busy !== 1'b0)
            $display("FAIL double: got %h/%b want 08/0", face_up, busy);
        else passes++;
        click(tx(2), ty(2));
        checks++; if (matched !== 8'h0C || face_up !== 8'h00)
            $display("FAIL pair23: got %h/%h want 0C/00", matched, face_up);
        else passes++;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        click(tx(0), ty(0));
        click(tx(2), ty(2));
        checks++; if (busy !== 1'b1) $display("FAIL pre_rst_busy: got %b want 1", busy);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (face_up !== 8'h00 || matched !== 8'h00 || busy !== 1'b0 || rgb_out !== 12'h0)
            $display("FAIL async_rst: got %h/%h/%b/%h want 00/00/0/000",
                     face_up, matched, busy, rgb_out);
        else passes++;
        rst = 1'b0;
        tick();
        click(tx(4), ty(4));
        checks++; if (face_up !== 8'h10) $display("FAIL rst_idle: got %h want 10", face_up);
        else passes++;
        click(tx(5), ty(5));
        checks++; if (matched !== 8'h30) $display("FAIL rst_pair: got %h want 30", matched);
        else passes++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int p = 0; p < 4; p++) begin
            click(tx(2 * p), ty(2 * p));
            click(tx(2 * p + 1), ty(2 * p + 1));
        end
        checks++; if (matched !== 8'hFF || face_up !== 8'h00)
            $display("FAIL all_matched: got %h/%h want FF/00", matched, face_up);
        else passes++;
        click(tx(6), ty(6));
        checks++; if (matched !== 8'hFF || face_up !== 8'h00 || busy !== 1'b0)
            $display("FAIL static: got %h/%h/%b want FF/00/0", matched, face_up, busy);
        else passes++;
    endtask

    initial begin
        rst = 1'b0;
        mouse_left = 1'b0;
        xpos = '0; ypos = '0;
        hcount = '0; vcount = '0;
        rgb_front = 12'hABC;
        rgb_back  = 12'h123;
        for (int t = 0; t < 8; t++) tile_key[t*3 +: 3] = 3'(t / 2);
        #2;
        test_reset();
        test_flip_match();
        test_mismatch();
        test_hit_edges();
        test_reset_mid_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
